// File: rtl/ex_stage.sv
// ex_stage: execute stage with operand forwarding, ALU, branch resolve and a single-entry output register
module ex_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    input  logic [XLEN-1:0] in_imm,
    input  logic [RA_W-1:0] in_rs1_addr,
    input  logic [RA_W-1:0] in_rs2_addr,
    input  logic [RA_W-1:0] in_rd_addr,
    input  logic            in_rd_we,
    input  logic [3:0]      in_alu_op,
    input  logic            in_a_sel,
    input  logic            in_b_sel,
    input  logic [1:0]      in_br_type,
    input  logic            wb_we,
    input  logic [RA_W-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [RA_W-1:0] out_rd_addr,
    output logic            out_rd_we,
    output logic            out_zero,
    output logic            out_br_taken,
    output logic [XLEN-1:0] out_br_target,
    output logic            out_illegal,
    output logic [31:0]     ex_count
);
    logic            accept, handoff, illegal, shift_op, taken;
    logic [XLEN-1:0] rs1, rs2, in0, in1_raw, in1, alu;

    function automatic logic [XLEN-1:0] fwd(input logic [RA_W-1:0] a, input logic [XLEN-1:0] v);
        return a == '0 ? '0 :
               (out_valid && out_rd_we && out_rd_addr == a) ? out_result :
               (wb_we && wb_rd == a) ? wb_data : v;
    endfunction

    assign in_ready = !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign handoff  = out_valid && out_ready;

    always_comb begin
        rs1      = fwd(in_rs1_addr, in_rs1_val);
        rs2      = fwd(in_rs2_addr, in_rs2_val);
        shift_op = in_alu_op inside {4'd7, 4'd8, 4'd9};
        illegal  = in_alu_op > 4'd9;
        in0      = in_a_sel ? in_pc : rs1;
        in1_raw  = in_b_sel ? in_imm : rs2;
        in1      = shift_op ? {{(XLEN-5){1'b0}}, in1_raw[4:0]} : in1_raw;
        taken    = in_br_type == 2'b01 ? rs1 == rs2 : in_br_type == 2'b10 ? rs1 != rs2 : 1'b0;
        case (in_alu_op)
            4'd0:    alu = in0 + in1;
            4'd1:    alu = in0 - in1;
            4'd2:    alu = in0 & in1;
            4'd3:    alu = in0 | in1;
            4'd4:    alu = in0 ^ in1;
            4'd5:    alu = {{(XLEN-1){1'b0}}, in0 < in1};
            4'd6:    alu = {{(XLEN-1){1'b0}}, $signed(in0) < $signed(in1)};
            4'd7:    alu = in0 << in1[4:0];
            4'd8:    alu = in0 >> in1[4:0];
            4'd9:    alu = $signed(in0) >>> in1[4:0];
            default: alu = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_rd_addr   <= '0;
            out_rd_we     <= 1'b0;
            out_zero      <= 1'b0;
            out_br_taken  <= 1'b0;
            out_br_target <= '0;
            out_illegal   <= 1'b0;
            ex_count      <= '0;
        end else begin
            if (handoff)
                ex_count <= ex_count + 32'd1;
            if (accept) begin
                out_valid     <= 1'b1;
                out_result    <= alu;
                out_rd_addr   <= in_rd_addr;
                out_rd_we     <= in_rd_we && !illegal;
                out_zero      <= alu == '0;
                out_br_taken  <= taken;
                out_br_target <= in_pc + in_imm;
                out_illegal   <= illegal;
            end else if (handoff || flush) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed and random stimulus with a queue scoreboard of expected results
module tb_ex_stage;
    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] in_pc = '0, in_rs1_val = '0, in_rs2_val = '0, in_imm = '0;
    logic [4:0]  in_rs1_addr = '0, in_rs2_addr = '0, in_rd_addr = '0;
    logic        in_rd_we = 1'b0;
    logic [3:0]  in_alu_op = '0;
    logic        in_a_sel = 1'b0, in_b_sel = 1'b0;
    logic [1:0]  in_br_type = '0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        flush = 1'b0, out_valid, out_ready = 1'b1;
    logic [31:0] out_result, out_br_target, ex_count;
    logic [4:0]  out_rd_addr;
    logic        out_rd_we, out_zero, out_br_taken, out_illegal;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        we, zero, br, ill;
        logic [31:0] tgt;
    } item_t;

    item_t       q[$];
    logic        m_valid = 1'b0;
    logic [31:0] m_cnt = '0;
    int          total = 0, bad = 0;

    ex_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
        .in_rd_we(in_rd_we), .in_alu_op(in_alu_op), .in_a_sel(in_a_sel), .in_b_sel(in_b_sel),
        .in_br_type(in_br_type), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we), .out_zero(out_zero),
        .out_br_taken(out_br_taken), .out_br_target(out_br_target), .out_illegal(out_illegal),
        .ex_count(ex_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] v);
        if (a == 5'd0) return 32'd0;
        if (m_valid && q.size() > 0 && q[0].we && q[0].rd == a) return q[0].res;
        if (wb_we && wb_rd == a) return wb_data;
        return v;
    endfunction

    function automatic item_t model();
        item_t       it;
        logic [31:0] r1, r2, a, b;
        r1 = fwd(in_rs1_addr, in_rs1_val);
        r2 = fwd(in_rs2_addr, in_rs2_val);
        a  = in_a_sel ? in_pc : r1;
        b  = in_b_sel ? in_imm : r2;
        if (in_alu_op >= 4'd7 && in_alu_op <= 4'd9) b = b & 32'h1F;
        case (in_alu_op)
            4'd0: it.res = a + b;
            4'd1: it.res = a - b;
            4'd2: it.res = a & b;
            4'd3: it.res = a | b;
            4'd4: it.res = a ^ b;
            4'd5: it.res = (a < b) ? 32'd1 : 32'd0;
            4'd6: it.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7: it.res = a << b;
            4'd8: it.res = a >> b;
            4'd9: it.res = 32'($signed(a) >>> b);
            default: it.res = 32'd0;
        endcase
        it.ill  = in_alu_op > 4'd9;
        it.rd   = in_rd_addr;
        it.we   = in_rd_we && !it.ill;
        it.zero = it.res == 32'd0;
        it.br   = (in_br_type == 2'b01 && r1 == r2) || (in_br_type == 2'b10 && r1 != r2);
        it.tgt  = in_pc + in_imm;
        return it;
    endfunction

    task automatic set_op(input logic [3:0] op, input logic [4:0] a1, input logic [31:0] v1,
                          input logic [4:0] a2, input logic [31:0] v2, input logic [31:0] imm,
                          input logic [31:0] pc, input logic asel, input logic bsel,
                          input logic [1:0] br, input logic [4:0] rd, input logic we);
        in_valid = 1'b1; in_alu_op = op; in_rs1_addr = a1; in_rs1_val = v1;
        in_rs2_addr = a2; in_rs2_val = v2; in_imm = imm; in_pc = pc;
        in_a_sel = asel; in_b_sel = bsel; in_br_type = br; in_rd_addr = rd; in_rd_we = we;
    endtask

    // One clock: check ready and any handoff before the edge, then state after it.
    task automatic tick();
        item_t it;
        logic  exp_ready, handoff;
        #1;
        exp_ready = !flush && (!m_valid || out_ready);
        chk("in_ready", in_ready, exp_ready);
        handoff = m_valid && out_ready;
        it = model();
        if (handoff) begin
            chk("result", out_result, q[0].res);
            chk("rd_addr", out_rd_addr, q[0].rd);
            chk("rd_we", out_rd_we, q[0].we);
            chk("zero", out_zero, q[0].zero);
            chk("br_taken", out_br_taken, q[0].br);
            chk("br_target", out_br_target, q[0].tgt);
            chk("illegal", out_illegal, q[0].ill);
            m_cnt++;
        end
        if (m_valid && (handoff || flush)) void'(q.pop_front());
        if (in_valid && exp_ready) begin
            q.push_back(it);
            m_valid = 1'b1;
        end else if (handoff || flush) m_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, m_valid);
        chk("ex_count", ex_count, m_cnt);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        m_valid = 1'b0;
        m_cnt = '0;
        chk("rst_valid", out_valid, 0);
        chk("rst_count", ex_count, 0);
        chk("rst_result", out_result, 0);
        chk("rst_flags", {out_rd_we, out_zero, out_br_taken, out_illegal}, 0);
        chk("rst_ready", in_ready, 1);
    endtask

    initial begin
        logic [31:0] held, cnt0;
        @(posedge clk);
        do_reset();
        // ADD wraps into the sign bit
        set_op(4'd0, 5'd1, 32'h7FFF_FFFF, 5'd0, 0, 32'd1, 0, 0, 1, 2'b00, 5'd3, 1);
        tick();
        chk("add_ovf", out_result, 32'h8000_0000);
        chk("add_zero", out_zero, 0);
        // A: x5 <- 0 - 1; B reads x5 with stale RF and a competing writeback
        set_op(4'd1, 5'd0, 0, 5'd0, 0, 32'd1, 0, 0, 1, 2'b00, 5'd5, 1);
        tick();
        set_op(4'd0, 5'd5, 0, 5'd0, 0, 0, 0, 0, 0, 2'b00, 5'd6, 1);
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'd3;
        tick();
        wb_we = 1'b0;
        chk("ex_fwd", out_result, 32'hFFFF_FFFF);
        // writeback forward when the EX register does not match
        set_op(4'd0, 5'd7, 32'd100, 5'd0, 0, 0, 0, 0, 0, 2'b00, 5'd8, 1);
        wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'd9;
        tick();
        wb_we = 1'b0;
        chk("wb_fwd", out_result, 32'd9);
        set_op(4'd7, 5'd1, 32'd1, 5'd2, 32'h0F00_0002, 0, 0, 0, 0, 2'b00, 5'd9, 1);
        tick();
        chk("sll_mask", out_result, 32'd4);
        set_op(4'd9, 5'd1, 32'h8000_0000, 5'd0, 0, 32'd36, 0, 0, 1, 2'b00, 5'd9, 1);
        tick();
        chk("sra", out_result, 32'hF800_0000);
        set_op(4'd6, 5'd1, 32'hFFFF_FFFF, 5'd2, 32'd1, 0, 0, 0, 0, 2'b00, 5'd9, 1);
        tick();
        chk("slt", out_result, 32'd1);
        set_op(4'd5, 5'd1, 32'hFFFF_FFFF, 5'd2, 32'd1, 0, 0, 0, 0, 2'b00, 5'd9, 1);
        tick();
        chk("sltu", out_result, 32'd0);
        chk("sltu_zero", out_zero, 1);
        // backpressure: three stalled cycles then release
        out_ready = 1'b0;
        set_op(4'd4, 5'd1, 32'hA5A5_0000, 5'd2, 32'h0000_5A5A, 0, 0, 0, 0, 2'b00, 5'd4, 1);
        held = out_result;
        cnt0 = ex_count;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold", out_result, held);
        end
        chk("stall_count", ex_count, cnt0);
        out_ready = 1'b1;
        tick();
        chk("release_count", ex_count, cnt0 + 1);
        chk("release_load", out_result, 32'hA5A5_5A5A);
        set_op(4'd0, 5'd1, 32'h8000_0000, 5'd2, 32'h8000_0000, 32'hFFFF_FFF0, 32'h100, 1, 1, 2'b10, 5'd0, 0);
        tick();
        chk("bne_taken", out_br_taken, 0);
        chk("bne_target", out_br_target, 32'h0000_00F0);
        set_op(4'd0, 5'd1, 32'h8000_0000, 5'd2, 32'h8000_0000, 32'd8, 32'h200, 1, 1, 2'b01, 5'd0, 0);
        tick();
        chk("beq_taken", out_br_taken, 1);
        // flush with a held op and a new op offered
        out_ready = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_valid", out_valid, 0);
        out_ready = 1'b1;
        set_op(4'hC, 5'd1, 32'd7, 5'd2, 32'd7, 0, 0, 0, 0, 2'b00, 5'd3, 1);
        tick();
        chk("ill_flag", out_illegal, 1);
        chk("ill_result", out_result, 0);
        chk("ill_we", out_rd_we, 0);
        // random traffic
        for (int i = 0; i < 300; i++) begin
            set_op(4'($urandom_range(0, 11)), 5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)),
                   $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom), 2'($urandom),
                   5'($urandom_range(0, 7)), 1'($urandom));
            in_valid = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            flush = $urandom_range(0, 9) == 0;
            wb_we = 1'($urandom); wb_rd = 5'($urandom_range(0, 7)); wb_data = $urandom;
            tick();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; wb_we = 1'b0;
        tick();
        tick();
        chk("drain", q.size(), 0);
        // reset while an op is held and out_ready is high
        set_op(4'd0, 5'd1, 32'd5, 5'd0, 0, 0, 0, 0, 0, 2'b00, 5'd2, 1);
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        do_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
